// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and constants for the shift_pipe barrel shifter.
//               Holds the operation-mode enumeration carried down the
//               pipeline, its width, and the pass-through mode used for
//               unsupported codes and saturated results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    // Width of the shift_select field and of the per-stage mode register.
    localparam int c_mode_w = 3;

    // Operation modes. The encodings match the external shift_select codes
    // so that the decoder can map them one-to-one. SH_PASS is an internal
    // code that makes every stage hand its data through untouched.
    typedef enum logic [c_mode_w-1:0] {
        SH_LSL  = 3'b000,
        SH_LSR  = 3'b001,
        SH_ASR  = 3'b010,
        SH_ROL  = 3'b011,
        SH_ROR  = 3'b100,
        SH_PASS = 3'b111
    } mode_e;

    // Mode applied to any operation that needs no further shifting:
    // undefined codes, disabled rotates and saturated out-of-range shifts.
    localparam mode_e c_pass_default = SH_PASS;

endpackage : shift_pkg

`default_nettype wire

// File: rtl/shift_pipe_stage.sv
// ============================================================================
// Module      : shift_pipe_stage
// Description : One pipeline stage of the barrel shifter. Conditionally
//               shifts or rotates its input by a fixed distance of 2^K
//               (when amount bit K is set) and captures the result, the mode
//               and the amount in a valid/ready hold register.
//
// Parameters  : WIDTH - data width (power of two, >= 4)
//               K     - stage index; this stage moves data by 2^K positions
//
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               up_valid   - upstream operation present
//               up_data    - upstream data
//               up_mode    - upstream operation mode
//               up_amount  - upstream shift amount (SHW bits)
//               down_ready - downstream can accept this stage's contents
//               valid      - stage holds an operation
//               data       - registered data after this stage's shift
//               mode       - registered mode
//               amount     - registered shift amount
//
// Build macro : SHIFT_PIPE_ROTATE_EN - include the wrap-around (ROL/ROR)
//               paths; when undefined those modes never reach the stage and
//               the logic is removed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_pipe_stage
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int K     = 0,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  mode_e            up_mode,
    input  logic [SHW-1:0]   up_amount,
    input  logic             down_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output mode_e            mode,
    output logic [SHW-1:0]   amount
);

    // Fixed distance handled by this stage.
    localparam int c_step = 1 << K;
`ifdef SHIFT_PIPE_ROTATE_EN
    // Distance by which the wrapped-around bits re-enter from the other end.
    localparam int c_back = WIDTH - c_step;
`endif

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_next;
    logic             w_load;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    mode_e            r_mode;
    logic [SHW-1:0]   r_amount;

    // Mode-dependent fixed shift; the amount bit then selects between the
    // shifted and the unshifted value.
    always_comb begin
        w_shifted = up_data;
        case (up_mode)
            SH_LSL:  w_shifted = up_data << c_step;
            SH_LSR:  w_shifted = up_data >> c_step;
            SH_ASR:  w_shifted = $signed(up_data) >>> c_step;
`ifdef SHIFT_PIPE_ROTATE_EN
            SH_ROL:  w_shifted = (up_data << c_step) | (up_data >> c_back);
            SH_ROR:  w_shifted = (up_data >> c_step) | (up_data << c_back);
`endif
            default: w_shifted = up_data;
        endcase
        w_next = up_amount[K] ? w_shifted : up_data;
    end

    // The register may load whenever it is empty or its contents leave
    // this cycle; otherwise everything is held.
    assign w_load = ~r_valid | down_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_mode   <= SH_LSL;
            r_amount <= '0;
        end else if (w_load) begin
            r_valid <= up_valid;
            // Payload only moves with a real operation, which keeps the
            // visible result quiet between transactions.
            if (up_valid) begin
                r_data   <= w_next;
                r_mode   <= up_mode;
                r_amount <= up_amount;
            end
        end
    end

    assign valid  = r_valid;
    assign data   = r_data;
    assign mode   = r_mode;
    assign amount = r_amount;

endmodule : shift_pipe_stage

`default_nettype wire

// File: rtl/shift_pipe.sv
// ============================================================================
// Module      : shift_pipe
// Description : Pipelined barrel shifter with valid/ready handshakes on both
//               sides. Supports logical left, logical right and arithmetic
//               right shifts, plus optional rotates. The shift distance is
//               resolved one bit per stage over SHW = log2(WIDTH) registered
//               stages, sustaining one operation per clock with full
//               backpressure.
//
// Parameters  : WIDTH - data width (power of two, >= 4)
//               SHW   - derived, number of pipeline stages
//
// Ports       : clk          - rising-edge clock
//               rst_n        - asynchronous active-low reset
//               in_valid     - operation presented
//               in_ready     - operation accepted on in_valid & in_ready
//               in1          - operand to shift (WIDTH)
//               in2          - unsigned shift amount (SHW+1 bits)
//               shift_select - 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR,
//                              other codes pass in1 through
//               out_valid    - result available
//               out_ready    - downstream accepts on out_valid & out_ready
//               result       - shifted value (WIDTH)
//               out_zero     - result == 0
//
// Build macro : SHIFT_PIPE_ROTATE_EN - enables ROL/ROR. When undefined,
//               codes 011 and 100 behave as pass-through with the same
//               latency as every other operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_pipe
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in1,
    input  logic [SHW:0]        in2,
    input  logic [c_mode_w-1:0] shift_select,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                out_zero
);

    // Index 0 is the decoded input; index k+1 is the output of stage k.
    logic             w_valid  [0:SHW];
    logic [WIDTH-1:0] w_data   [0:SHW];
    mode_e            w_mode   [0:SHW];
    logic [SHW-1:0]   w_amount [0:SHW];

    // w_rdy[k] : stage k can take a new operation this cycle.
    // w_rdy[SHW] is the downstream acceptance.
    logic [SHW:0]     w_rdy;

    // ------------------------------------------------------------------------
    // Input decode. Out-of-range logical shifts and arithmetic shifts are
    // saturated here so the stages only ever see in-range amounts; rotates
    // keep the low SHW bits, which is the amount modulo WIDTH.
    // ------------------------------------------------------------------------
    always_comb begin
        w_data[0]   = in1;
        w_mode[0]   = c_pass_default;
        w_amount[0] = '0;
        case (shift_select)
            SH_LSL: begin
                if (in2[SHW]) begin
                    w_data[0] = '0;
                end else begin
                    w_mode[0]   = SH_LSL;
                    w_amount[0] = in2[SHW-1:0];
                end
            end
            SH_LSR: begin
                if (in2[SHW]) begin
                    w_data[0] = '0;
                end else begin
                    w_mode[0]   = SH_LSR;
                    w_amount[0] = in2[SHW-1:0];
                end
            end
            SH_ASR: begin
                if (in2[SHW]) begin
                    w_data[0] = {WIDTH{in1[WIDTH-1]}};
                end else begin
                    w_mode[0]   = SH_ASR;
                    w_amount[0] = in2[SHW-1:0];
                end
            end
`ifdef SHIFT_PIPE_ROTATE_EN
            SH_ROL: begin
                w_mode[0]   = SH_ROL;
                w_amount[0] = in2[SHW-1:0];
            end
            SH_ROR: begin
                w_mode[0]   = SH_ROR;
                w_amount[0] = in2[SHW-1:0];
            end
`endif
            default: begin
                w_mode[0]   = c_pass_default;
                w_amount[0] = '0;
            end
        endcase
    end

    assign w_valid[0] = in_valid;

    // ------------------------------------------------------------------------
    // Ready chain, evaluated from the output back to the input. A stage can
    // accept when it is empty or when what it holds moves on this cycle, so
    // a full pipeline still takes one operation per cycle while draining.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rdy      = '0;
        w_rdy[SHW] = out_ready;
        for (int k = SHW - 1; k >= 0; k--) begin
            w_rdy[k] = ~w_valid[k+1] | w_rdy[k+1];
        end
    end

    assign in_ready = w_rdy[0];

    // ------------------------------------------------------------------------
    // Shift stages: stage k moves data by 2^k when amount bit k is set.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_pipe_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .up_valid   (w_valid[k]),
            .up_data    (w_data[k]),
            .up_mode    (w_mode[k]),
            .up_amount  (w_amount[k]),
            .down_ready (w_rdy[k+1]),
            .valid      (w_valid[k+1]),
            .data       (w_data[k+1]),
            .mode       (w_mode[k+1]),
            .amount     (w_amount[k+1])
        );
    end

    assign out_valid = w_valid[SHW];
    assign result    = w_data[SHW];
    assign out_zero  = (result == '0);

    // Mode and amount are no longer needed once the last stage has applied
    // its shift.
    logic w_unused_tail;
    assign w_unused_tail = ^{w_mode[SHW], w_amount[SHW]};

endmodule : shift_pipe

`default_nettype wire

// File: tb/tb_shift_pipe.sv
// ============================================================================
// Module      : tb_shift_pipe
// Description : Self-checking bench for shift_pipe (WIDTH = 8). Directed
//               vector table, random streaming against a reference model,
//               backpressure, and reset with operations in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_pipe;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;
`ifdef SHIFT_PIPE_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in1 = 8'h00;
    logic [3:0]   in2 = 4'h0;
    logic [2:0]   shift_select = 3'b000;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   result;
    logic         out_zero;

    shift_pipe #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in1          (in1),
        .in2          (in2),
        .shift_select (shift_select),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .out_zero     (out_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definition of each mode.
    function automatic logic [7:0] model(input logic [7:0] a, input logic [3:0] amt,
                                         input logic [2:0] sel);
        int x, sx, n, m;
        x  = int'(a);
        sx = a[7] ? x - 256 : x;
        n  = int'(amt);
        m  = n % WIDTH;
        case (sel)
            3'd0:    return 8'(x << n);
            3'd1:    return 8'(x >> n);
            3'd2:    return 8'(sx >>> n);
            3'd3:    return ROT ? 8'((x << m) | (x >> (WIDTH - m))) : a;
            3'd4:    return ROT ? 8'((x >> m) | (x << (WIDTH - m))) : a;
            default: return a;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------------
    typedef struct {
        string      name;
        logic [7:0] a;
        logic [3:0] amt;
        logic [2:0] sel;
        logic [7:0] exp;
        logic       zero;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic run_single(input string name, input logic [7:0] a, input logic [3:0] amt,
                              input logic [2:0] sel, input logic [7:0] exp, input logic exp_z);
        int lat;
        @(posedge clk); #1;
        out_ready    = 1'b1;
        in_valid     = 1'b1;
        in1          = a;
        in2          = amt;
        shift_select = sel;
        #1;
        check({name, " in_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, lat, SHW);
        check({name, " result"}, result, exp);
        check({name, " zero"}, out_zero, exp_z);
    endtask

    // ------------------------------------------------------------------------
    // Streaming harness: one call per clock cycle
    // ------------------------------------------------------------------------
    logic [7:0] op_a   [8];
    logic [3:0] op_amt [8];
    logic [2:0] op_sel [8];
    logic [7:0] q [$];
    int idx, rcvd, accepts, ready_low, cyc, first_rx, last_rx;

    task automatic stream_reset();
        idx = 0; rcvd = 0; accepts = 0; ready_low = 0; first_rx = 0; last_rx = 0;
        q.delete();
    endtask

    task automatic step(input logic ordy, input int n_ops);
        logic [7:0] exp;
        @(posedge clk); #1;
        cyc++;
        out_ready = ordy;
        if (idx < n_ops) begin
            in_valid     = 1'b1;
            in1          = op_a[idx];
            in2          = op_amt[idx];
            shift_select = op_sel[idx];
        end else begin
            in_valid = 1'b0;
        end
        #1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_extra: got 0x%0h expected no output", result);
            end else begin
                exp = q.pop_front();
                check("stream_result", result, exp);
                check("stream_zero", out_zero, exp == 8'h00);
            end
            rcvd++;
            if (rcvd == 1) first_rx = cyc;
            last_rx = cyc;
        end
        if (in_valid && !in_ready) ready_low++;
        if (in_valid && in_ready) begin
            q.push_back(model(in1, in2, shift_select));
            idx++;
            accepts++;
        end
    endtask

    task automatic randomize_ops(input int n);
        for (int i = 0; i < n; i++) begin
            op_a[i]   = 8'($urandom);
            op_amt[i] = 4'($urandom_range(0, 15));
            op_sel[i] = 3'($urandom_range(0, 7));
        end
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        cyc = 0;
        vecs[0]  = '{"lsl_81_1",   8'h81, 4'd1,  3'b000, 8'h02, 1'b0};
        vecs[1]  = '{"lsr_90_2",   8'h90, 4'd2,  3'b001, 8'h24, 1'b0};
        vecs[2]  = '{"asr_90_2",   8'h90, 4'd2,  3'b010, 8'hE4, 1'b0};
        vecs[3]  = '{"lsl_5a_9",   8'h5A, 4'd9,  3'b000, 8'h00, 1'b1};
        vecs[4]  = '{"asr_80_9",   8'h80, 4'd9,  3'b010, 8'hFF, 1'b0};
        vecs[5]  = '{"asr_7f_9",   8'h7F, 4'd9,  3'b010, 8'h00, 1'b1};
        vecs[6]  = '{"ror_81_9",   8'h81, 4'd9,  3'b100, ROT ? 8'hC0 : 8'h81, 1'b0};
        vecs[7]  = '{"rol_81_9",   8'h81, 4'd9,  3'b011, ROT ? 8'h03 : 8'h81, 1'b0};
        vecs[8]  = '{"ror_81_1",   8'h81, 4'd1,  3'b100, ROT ? 8'hC0 : 8'h81, 1'b0};
        vecs[9]  = '{"mode7_3c",   8'h3C, 4'd3,  3'b111, 8'h3C, 1'b0};
        vecs[10] = '{"lsl_a5_0",   8'hA5, 4'd0,  3'b000, 8'hA5, 1'b0};
        vecs[11] = '{"lsr_ff_7",   8'hFF, 4'd7,  3'b001, 8'h01, 1'b0};
        vecs[12] = '{"lsl_01_15",  8'h01, 4'd15, 3'b000, 8'h00, 1'b1};
        vecs[13] = '{"asr_81_7",   8'h81, 4'd7,  3'b010, 8'hFF, 1'b0};
        vecs[14] = '{"mode5_12",   8'h12, 4'd2,  3'b101, 8'h12, 1'b0};

        // Reset state
        #1;
        check("rst out_valid", out_valid, 1'b0);
        check("rst result", result, 8'h00);
        check("rst out_zero", out_zero, 1'b1);
        check("rst in_ready", in_ready, 1'b1);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < NV; i++) begin
            run_single(vecs[i].name, vecs[i].a, vecs[i].amt, vecs[i].sel,
                       vecs[i].exp, vecs[i].zero);
        end

        // Back-to-back random stream
        stream_reset();
        randomize_ops(8);
        for (int c = 0; c < 14; c++) step(1'b1, 8);
        check("b2b received", rcvd, 8);
        check("b2b one per cycle", last_rx - first_rx, 7);
        check("b2b in_ready low", ready_low, 0);
        check("b2b leftover", q.size(), 0);

        // Backpressure: five offered with the output stalled
        stream_reset();
        randomize_ops(5);
        for (int c = 0; c < 6; c++) step(1'b0, 5);
        check("bp accepts", accepts, SHW);
        check("bp in_ready", in_ready, 1'b0);
        check("bp out_valid", out_valid, 1'b1);
        check("bp hold result", result, q[0]);
        step(1'b0, 5);
        step(1'b0, 5);
        check("bp stable result", result, q[0]);
        check("bp stable zero", out_zero, q[0] == 8'h00);
        for (int c = 0; c < 30 && (rcvd < 5 || idx < 5); c++) step(1'b1, 5);
        for (int c = 0; c < 4; c++) step(1'b1, 5);
        check("bp drained", rcvd, 5);
        check("bp accepted", accepts, 5);
        check("bp leftover", q.size(), 0);

        // Reset with two operations in flight
        stream_reset();
        randomize_ops(2);
        op_sel[0] = 3'b111;
        op_sel[1] = 3'b111;
        step(1'b0, 2);
        step(1'b0, 2);
        step(1'b0, 0);
        step(1'b0, 0);
        check("rip accepts", accepts, 2);
        check("rip out_valid before", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rip out_valid async", out_valid, 1'b0);
        check("rip in_ready", in_ready, 1'b1);
        check("rip result", result, 8'h00);
        @(posedge clk); #2;
        rst_n = 1'b1;
        q.delete();
        #1;
        check("post rst in_ready", in_ready, 1'b1);
        run_single("post_rst_lsl_01_7", 8'h01, 4'd7, 3'b000, 8'h80, 1'b0);

        // Nothing may emerge afterwards
        stream_reset();
        for (int c = 0; c < 5; c++) step(1'b1, 0);
        check("idle no output", rcvd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule : tb_shift_pipe

`default_nettype wire
